pipe_control: RTL

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control_if.sv | 53 +++++
 rtl/pipe_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_if.sv
// Handshake and pipeline-control bundle between IF/ID, the pipe_control block and the datapath.
// The master side drives the IF/ID opcode and hazard inputs; the slave side is pipe_control.
interface pipe_control_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] opcode_in;
    logic            valid_in;
    logic            stall_in;
    logic            flush_in;

    logic            ready_out;
    logic            sp_hazard;

    logic            ex_valid;
    logic            ex_call;
    logic            ex_ret;
    logic            ex_branch;
    logic            ex_pop;
    logic            ex_reg_2_sel;
    logic            ex_sign_ext_sel;
    logic            ex_load_imm;
    logic [1:0]      ex_alu_src;
    logic [OP_W-1:0] ex_alu_op;

    logic            mem_valid;
    logic            mem_MemWrite;
    logic            mem_MemRead;
    logic            mem_src;
    logic            mem_OAMWrite;
    logic            mem_APUWrite;

    logic            wb_valid;
    logic            wb_RegWrite;
    logic            wb_mem_to_reg;

    modport master (
        output opcode_in, valid_in, stall_in, flush_in,
        input  ready_out, sp_hazard,
        input  ex_valid, ex_call, ex_ret, ex_branch, ex_pop, ex_reg_2_sel,
        input  ex_sign_ext_sel, ex_load_imm, ex_alu_src, ex_alu_op,
        input  mem_valid, mem_MemWrite, mem_MemRead, mem_src, mem_OAMWrite, mem_APUWrite,
        input  wb_valid, wb_RegWrite, wb_mem_to_reg
    );

    modport slave (
        input  opcode_in, valid_in, stall_in, flush_in,
        output ready_out, sp_hazard,
        output ex_valid, ex_call, ex_ret, ex_branch, ex_pop, ex_reg_2_sel,
        output ex_sign_ext_sel, ex_load_imm, ex_alu_src, ex_alu_op,
        output mem_valid, mem_MemWrite, mem_MemRead, mem_src, mem_OAMWrite, mem_APUWrite,
        output wb_valid, wb_RegWrite, wb_mem_to_reg
    );
endinterface

// File: rtl/pipe_control.sv
// Opcode decode plus ID/EX, EX/MEM and MEM/WB control registers, with a stack-pointer
// interlock counter that stalls back-to-back SP-modifying instructions.
module pipe_control #(
    parameter int OP_W       = 6,
    parameter int SP_HAZ_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    pipe_control_if.slave bus
);

    localparam logic [OP_W-1:0] ALU_ADD = {1'b1, {(OP_W-1){1'b0}}};
    localparam logic [OP_W-1:0] ALU_SUB = ALU_ADD | OP_W'(2);
    localparam logic [2:0]      SP_LOAD = 3'(SP_HAZ_CYC);

    typedef struct packed {
        logic            valid;
        logic            call;
        logic            ret;
        logic            branch;
        logic            pop;
        logic            reg_2_sel;
        logic            sign_ext_sel;
        logic            load_imm;
        logic [1:0]      alu_src;
        logic [OP_W-1:0] alu_op;
        logic            mem_write;
        logic            mem_read;
        logic            mem_src;
        logic            oam_write;
        logic            apu_write;
        logic            reg_write;
        logic            mem_to_reg;
    } id_ex_t;

    typedef struct packed {
        logic valid;
        logic mem_write;
        logic mem_read;
        logic mem_src;
        logic oam_write;
        logic apu_write;
        logic reg_write;
        logic mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
    } mem_wb_t;

    localparam id_ex_t ID_EX_BUBBLE = '{alu_op: ALU_ADD, default: '0};

    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;
    logic [2:0] sp_cnt_q, sp_cnt_d;

    id_ex_t     dec;
    logic       dec_sp_op;
    logic [2:0] cls;
    logic [2:0] fn;
    logic       stall;

    assign cls = bus.opcode_in[OP_W-1 -: 3];
    assign fn  = bus.opcode_in[2:0];

    // NOTE: every output of a combinational block gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        dec        = ID_EX_BUBBLE;
        dec.valid  = 1'b1;
        dec_sp_op  = 1'b0;

        if (cls[2]) begin
            dec.reg_write = 1'b1;
            dec.reg_2_sel = 1'b1;
            dec.alu_op    = bus.opcode_in;
            if (fn[1:0] == 2'b01)      dec.alu_src = 2'b01;
            else if (fn[2:1] == 2'b11) dec.alu_src = 2'b10;
        end else begin
            case (cls[1:0])
                2'b00: begin
                    dec.sign_ext_sel = 1'b1;
                    if (!fn[2]) begin
                        dec.branch  = 1'b1;
                        dec.alu_src = 2'b01;
                    end else if (!fn[0]) begin
                        dec.call      = 1'b1;
                        dec.reg_write = 1'b1;
                        dec.mem_write = 1'b1;
                        dec.mem_src   = 1'b1;
                        dec_sp_op     = 1'b1;
                    end else begin
                        dec.ret        = 1'b1;
                        dec.reg_write  = 1'b1;
                        dec.mem_read   = 1'b1;
                        dec.mem_to_reg = 1'b1;
                        dec.alu_op     = ALU_SUB;
                        dec_sp_op      = 1'b1;
                    end
                end
                2'b01: begin
                    if (!fn[2] && fn[0]) begin
                        dec.load_imm  = 1'b1;
                        dec.reg_write = 1'b1;
                    end else if (!fn[2]) begin
                        dec.mem_read   = 1'b1;
                        dec.mem_to_reg = 1'b1;
                        dec.reg_write  = 1'b1;
                        if (!fn[1]) begin
                            dec.alu_src = 2'b01;
                        end else begin
                            dec.pop    = 1'b1;
                            dec.alu_op = ALU_SUB;
                            dec_sp_op  = 1'b1;
                        end
                    end else begin
                        dec.mem_write = 1'b1;
                        if (!fn[1]) begin
                            dec.alu_src = 2'b01;
                            dec.alu_op  = ALU_SUB;
                        end else begin
                            dec.reg_write = 1'b1;
                            dec.mem_src   = 1'b1;
                            dec_sp_op     = 1'b1;
                        end
                    end
                end
                2'b10: begin
                    dec.oam_write = 1'b1;
                    dec.alu_src   = 2'b11;
                end
                default: begin
                    dec.apu_write = 1'b1;
                    dec.alu_src   = 2'b11;
                end
            endcase
        end
    end

    // The interlock only bites while an SP-op is waiting in IF/ID behind another SP-op.
    assign bus.sp_hazard = (sp_cnt_q != 3'd0) && bus.valid_in && dec_sp_op;
    assign stall         = bus.stall_in | bus.sp_hazard;
    assign bus.ready_out = rst | ~stall | bus.flush_in;

    always_comb begin
        id_ex_d  = ID_EX_BUBBLE;
        sp_cnt_d = (sp_cnt_q == 3'd0) ? 3'd0 : sp_cnt_q - 3'd1;

        ex_mem_d.valid      = id_ex_q.valid;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_src    = id_ex_q.mem_src;
        ex_mem_d.oam_write  = id_ex_q.oam_write;
        ex_mem_d.apu_write  = id_ex_q.apu_write;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;

        mem_wb_d.valid      = ex_mem_q.valid;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;

        if (bus.flush_in) begin
            ex_mem_d = '0;
            sp_cnt_d = 3'd0;
        end else if (!stall && bus.valid_in) begin
            id_ex_d = dec;
            if (dec_sp_op) sp_cnt_d = SP_LOAD;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q  <= ID_EX_BUBBLE;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            sp_cnt_q <= 3'd0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            sp_cnt_q <= sp_cnt_d;
        end
    end

    assign bus.ex_valid        = id_ex_q.valid;
    assign bus.ex_call         = id_ex_q.call;
    assign bus.ex_ret          = id_ex_q.ret;
    assign bus.ex_branch       = id_ex_q.branch;
    assign bus.ex_pop          = id_ex_q.pop;
    assign bus.ex_reg_2_sel    = id_ex_q.reg_2_sel;
    assign bus.ex_sign_ext_sel = id_ex_q.sign_ext_sel;
    assign bus.ex_load_imm     = id_ex_q.load_imm;
    assign bus.ex_alu_src      = id_ex_q.alu_src;
    assign bus.ex_alu_op       = id_ex_q.alu_op;

    assign bus.mem_valid    = ex_mem_q.valid;
    assign bus.mem_MemWrite = ex_mem_q.mem_write;
    assign bus.mem_MemRead  = ex_mem_q.mem_read;
    assign bus.mem_src      = ex_mem_q.mem_src;
    assign bus.mem_OAMWrite = ex_mem_q.oam_write;
    assign bus.mem_APUWrite = ex_mem_q.apu_write;

    assign bus.wb_valid      = mem_wb_q.valid;
    assign bus.wb_RegWrite   = mem_wb_q.reg_write;
    assign bus.wb_mem_to_reg = mem_wb_q.mem_to_reg;

    // Bubbles carry no write enables, so a write strobe never appears without its valid.
    a_mem_gated: assert property (@(posedge clk) disable iff (rst)
        !bus.mem_valid |-> !(bus.mem_MemWrite | bus.mem_MemRead | bus.mem_OAMWrite | bus.mem_APUWrite));
    a_wb_gated: assert property (@(posedge clk) disable iff (rst)
        !bus.wb_valid |-> !(bus.wb_RegWrite | bus.wb_mem_to_reg));

endmodule
